// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-stream arbiter.
// Imported by the top level and the round-robin picker.
package uart_tx_arbiter_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward
// from the slot after the previous owner, wrapping around.
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prev,
  output logic          found,
  output logic [IW-1:0] index
);

  // k = N revisits the previous owner last, so a lone requester can re-win.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(prev) + k) % N]) begin
        found = 1'b1;
        index = IW'((int'(prev) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART tx byte stream among
// several sources, with a stall watchdog that revokes a silent owner's grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int IDLE_TIMEOUT   = 1024,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [DATA_WIDTH*NUM_REQUESTERS-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]            req_last,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  output logic                                 tx_valid,
  output logic [DATA_WIDTH-1:0]                tx_data,
  input  logic                                 tx_ready,
  output logic                                 grant_valid,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    grant_index,
  output logic                                 timeout_event
);

  localparam int IW = idx_width(NUM_REQUESTERS);

  state_t          state, state_next;
  logic [IW-1:0]   owner, owner_next;
  logic            timeout_next;
  logic            pick_found;
  logic [IW-1:0]   pick_index;
  logic            locked;
  logic            owner_valid;
  logic            owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic            last_accept;
  logic            stall_expire;

  rr_picker #(
    .N  (NUM_REQUESTERS),
    .IW (IW)
  ) u_picker (
    .req   (req_valid),
    .prev  (owner),
    .found (pick_found),
    .index (pick_index)
  );

  // Handshake: a byte moves on any edge where valid and ready are both high;
  // the owner keeps data/last stable while valid is high and ready is low.
  assign locked      = (state == LOCKED);
  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign owner_data  = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign last_accept = locked && owner_valid && tx_ready && owner_last;

  assign grant_valid = locked;
  assign grant_index = owner;
  assign tx_valid    = locked && owner_valid;
  assign tx_data     = locked ? owner_data : '0;
  assign req_ready   = locked ? (NUM_REQUESTERS'(tx_ready) << owner) : '0;

  // Counter clears whenever the owner has a byte up, even if tx is back-pressuring.
  if (IDLE_TIMEOUT > 0) begin : g_wd
    logic [TIMEOUT_WIDTH-1:0] stall_cnt;
    logic                     owner_stall;

    assign owner_stall  = locked && !owner_valid;
    assign stall_expire = owner_stall &&
                          (stall_cnt == TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
      if (reset || !owner_stall || stall_expire) stall_cnt <= '0;
      else                                       stall_cnt <= stall_cnt + TIMEOUT_WIDTH'(1);
    end
  end else begin : g_no_wd
    assign stall_expire = 1'b0;
  end

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = LOCKED;
          owner_next = pick_index;
        end
      end
      LOCKED: begin
        // Last-beat acceptance takes priority over the watchdog.
        if (last_accept) begin
          state_next = IDLE;
        end else if (stall_expire) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= IW'(NUM_REQUESTERS - 1);
      timeout_event <= 1'b0;
    end else begin
      state         <= state_next;
      owner         <= owner_next;
      timeout_event <= timeout_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two byte-stream sources, an expected
// beat queue checked on every accepted tx byte, and cycle-exact checks.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        grant_valid;
  logic [0:0]  grant_index;
  logic        timeout_event;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  logic [8:0] exp_q[$];
  logic [1:0] acc_r = 2'b00;
  logic       ready_next = 1'b1;
  logic [8:0] exp_beat;
  logic       have_exp;

  logic [7:0] bp_data [6];
  logic       bp_ready [6];

  uart_tx_arbiter #(
    .NUM_REQUESTERS (2),
    .IDLE_TIMEOUT   (8),
    .TIMEOUT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index),
    .timeout_event (timeout_event)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Driver: present the head of each source queue.
  task automatic apply_src();
    req_valid = 2'b00;
    req_data  = '0;
    req_last  = 2'b00;
    if (src0_q.size() > 0) begin
      req_valid[0]   = 1'b1;
      req_data[7:0]  = src0_q[0][7:0];
      req_last[0]    = src0_q[0][8];
    end
    if (src1_q.size() > 0) begin
      req_valid[1]   = 1'b1;
      req_data[15:8] = src1_q[0][7:0];
      req_last[1]    = src1_q[0][8];
    end
    tx_ready = ready_next;
  endtask

  // One clock: retire accepted heads, drive the next cycle, settle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_r[0] && src0_q.size() > 0) void'(src0_q.pop_front());
    if (acc_r[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    apply_src();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted tx byte must match the head of exp_q.
  always @(negedge clk) begin
    acc_r = req_valid & req_ready;
    if (tx_valid && tx_ready) begin
      have_exp = (exp_q.size() > 0);
      exp_beat = have_exp ? exp_q.pop_front() : 9'h0;
      check("beat", {1'b1, grant_index, tx_data}, have_exp ? {1'b1, exp_beat} : 10'h0);
    end
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_data   = '0;
    req_last   = 2'b00;
    tx_ready   = 1'b0;
    bp_data    = '{8'h30, 8'h31, 8'h31, 8'h31, 8'h32, 8'h33};
    bp_ready   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    do_reset();
    check("rst_grant_valid", grant_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_index", grant_index, 1);
    check("rst_timeout", timeout_event, 0);

    // Single source: 0x48, 0x69(last)
    ready_next = 1'b1;
    src0_q.push_back({1'b0, 8'h48});
    src0_q.push_back({1'b1, 8'h69});
    exp_q.push_back({1'b0, 8'h48});
    exp_q.push_back({1'b0, 8'h69});
    apply_src();
    #1;
    check("t1_idle_grant", grant_valid, 0);
    check("t1_idle_ready", req_ready, 0);
    tick();
    check("t1_grant", grant_valid, 1);
    check("t1_index", grant_index, 0);
    check("t1_byte0", tx_data, 8'h48);
    check("t1_ready", req_ready, 2'b01);
    tick();
    check("t1_byte1", tx_data, 8'h69);
    check("t1_valid1", tx_valid, 1);
    tick();
    check("t1_release", grant_valid, 0);
    check("t1_tx_idle", tx_valid, 0);
    check("t1_index_hold", grant_index, 0);
    check("t1_no_timeout", timeout_event, 0);

    // Contention: two 3-byte packets each, order 0,1,0,1 with one idle gap
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        src0_q.push_back({(b == 2), 8'(8'h10 + 3*p + b)});
        src1_q.push_back({(b == 2), 8'(8'h20 + 3*p + b)});
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) exp_q.push_back({1'b0, 8'(8'h10 + 3*p + b)});
      for (int b = 0; b < 3; b++) exp_q.push_back({1'b1, 8'(8'h20 + 3*p + b)});
    end
    apply_src();
    #1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t2_grant_valid", grant_valid, (k % 4) != 3);
      if ((k % 4) != 3) check("t2_grant_index", grant_index, (k / 4) % 2);
    end
    check("t2_drain", exp_q.size(), 0);

    // Backpressure: tx_ready 1,0,0,1 then 1,1 over a 4-byte packet
    for (int b = 0; b < 4; b++) begin
      src0_q.push_back({(b == 3), 8'(8'h30 + b)});
      exp_q.push_back({1'b0, 8'(8'h30 + b)});
    end
    apply_src();
    #1;
    for (int c = 0; c < 6; c++) begin
      ready_next = bp_ready[c];
      tick();
      check("t3_data", tx_data, bp_data[c]);
      check("t3_ready", req_ready, {1'b0, bp_ready[c]});
      check("t3_no_timeout", timeout_event, 0);
    end
    ready_next = 1'b1;
    tick();
    check("t3_release", grant_valid, 0);
    check("t3_drain", exp_q.size(), 0);

    // Watchdog: owner 1 sends one non-last byte then goes silent
    src1_q.push_back({1'b0, 8'h40});
    src0_q.push_back({1'b1, 8'h50});
    exp_q.push_back({1'b1, 8'h40});
    exp_q.push_back({1'b0, 8'h50});
    apply_src();
    #1;
    tick();
    check("t4_index", grant_index, 1);
    check("t4_byte", tx_data, 8'h40);
    check("t4_ready", req_ready, 2'b10);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("t4_hold_grant", grant_valid, 1);
      check("t4_hold_no_timeout", timeout_event, 0);
      check("t4_hold_tx_valid", tx_valid, 0);
    end
    tick();
    check("t4_released", grant_valid, 0);
    check("t4_timeout_pulse", timeout_event, 1);
    tick();
    check("t4_next_grant", grant_valid, 1);
    check("t4_next_index", grant_index, 0);
    check("t4_pulse_end", timeout_event, 0);
    check("t4_next_byte", tx_data, 8'h50);
    tick();
    check("t4_done", grant_valid, 0);

    // Reset mid-packet after the 2nd of 4 bytes
    for (int b = 0; b < 4; b++) src0_q.push_back({(b == 3), 8'(8'h60 + b)});
    exp_q.push_back({1'b0, 8'h60});
    exp_q.push_back({1'b0, 8'h61});
    apply_src();
    #1;
    tick();
    check("t5_byte0", tx_data, 8'h60);
    tick();
    check("t5_byte1", tx_data, 8'h61);
    tick();
    check("t5_byte2", tx_data, 8'h62);
    reset      = 1'b1;
    ready_next = 1'b0;
    tx_ready   = 1'b0;
    #1;
    check("t5_pre_reset_valid", tx_valid, 1);
    tick();
    check("t5_rst_tx_valid", tx_valid, 0);
    check("t5_rst_grant", grant_valid, 0);
    check("t5_rst_index", grant_index, 1);
    reset = 1'b0;
    src0_q.delete();
    src1_q.delete();
    src0_q.push_back({1'b1, 8'h70});
    src1_q.push_back({1'b1, 8'h71});
    exp_q.push_back({1'b0, 8'h70});
    exp_q.push_back({1'b1, 8'h71});
    ready_next = 1'b1;
    apply_src();
    #1;
    tick();
    check("t5_regrant_index", grant_index, 0);
    check("t5_regrant_byte", tx_data, 8'h70);
    tick();
    check("t5_gap", grant_valid, 0);
    tick();
    check("t5_second_index", grant_index, 1);
    check("t5_second_byte", tx_data, 8'h71);
    tick();
    check("t5_idle", grant_valid, 0);

    check("final_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single UART transmit byte stream (towards the tx serializer inside the SoC) between NUM_REQUESTERS byte-stream sources (e.g. debug monitor, CPU console).
A grant is held from a requester's first byte until its byte flagged last is accepted, so packets never interleave on the wire.
A stall watchdog revokes the grant of a requester that goes silent mid-packet.

Parameters:
NUM_REQUESTERS, 2, number of requesters; legal range 2..8.
IDLE_TIMEOUT, 1024, consecutive owner-stall cycles before forced release; 0 disables the watchdog.
TIMEOUT_WIDTH, 16, width of the stall counter; must satisfy IDLE_TIMEOUT < 2^TIMEOUT_WIDTH.

Ports:
clk  in  1  single clock domain
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQUESTERS  per-requester byte valid
req_data  in  8*NUM_REQUESTERS  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  in  NUM_REQUESTERS  byte is final of packet
req_ready  out  NUM_REQUESTERS  per-requester accept
tx_valid  out  1  byte valid to UART transmitter
tx_data  out  8  byte to UART transmitter
tx_ready  in  1  UART transmitter accepts byte
grant_valid  out  1  a requester currently owns the stream
grant_index  out  $clog2(NUM_REQUESTERS)  current or most recent owner
timeout_event  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset: clk and reset only; reset is synchronous, active-high. Any edge with reset=1 forces IDLE, owner=NUM_REQUESTERS-1, stall counter=0, timeout_event=0. All outputs then read 0 except grant_index=NUM_REQUESTERS-1.
- Reset mid-packet: the packet is abandoned with no flush, and tx_valid drops on the edge that samples reset. The requester must restart the packet after reset.
- States: IDLE, LOCKED.
- IDLE:
  - grant_valid=0, tx_valid=0, req_ready all 0.
  - If any req_valid is set, pick the first set bit scanning from (owner+1) mod N upward with wrap. Load owner, go to LOCKED next edge.
  - If no req_valid is set, stay in IDLE.
- LOCKED (combinational pass-through, no added latency):
  - grant_valid=1.
  - tx_valid = req_valid[owner]; tx_data = req_data[owner].
  - req_ready[owner] = tx_ready; all other req_ready = 0.
  - Beat accepted when tx_valid & tx_ready.
  - Accepted beat with req_last[owner]=1: go to IDLE next edge.
- Latency: a request arriving in IDLE is first presented on tx the cycle after. There is one mandatory IDLE bubble between consecutive packets, including back-to-back packets from the same requester.
- Fairness: owner is updated only on a new grant. Rotation starts after the last owner, so requester 0 wins first after reset. A continuously requesting source gets at most one packet per round.
- Watchdog (IDLE_TIMEOUT>0), active in LOCKED only:
  - The counter increments each cycle req_valid[owner]=0 and clears on any cycle req_valid[owner]=1.
  - tx_ready low with valid high is not a stall; the counter clears.
  - When the counter equals IDLE_TIMEOUT-1 and req_valid[owner]=0: go to IDLE next edge, pulse timeout_event for exactly that one following cycle, clear the counter.
  - The owner's remaining bytes then compete as a new packet.
- Simultaneous last-beat acceptance and timeout on the same edge: last-beat acceptance wins and timeout_event stays 0. This cannot occur given the rules above, but the implementation must guarantee it.
- Non-owner req_valid/req_data are ignored and may change freely. The owner must hold req_data/req_last stable while valid and not ready.
- IDLE_TIMEOUT=0: counter logic removed; a stalled owner holds the grant indefinitely.

Decomposition:
- Package uart_tx_arbiter_pkg:
  - state enum {IDLE, LOCKED}
  - index-width localparam helper
  - constant DATA_WIDTH=8
- Sub-module rr_picker: combinational. Inputs request vector and previous owner; outputs found flag and next index. Reusable by future bus arbiters.
- Stall counter and FSM stay in uart_tx_arbiter.

Test Plan:
- Single source: req 0 sends packet 0x48,0x69 (last on 0x69), tx_ready=1 -> tx_data 0x48 then 0x69 on the two cycles after the request is seen; grant_index=0; back to IDLE; no timeout_event.
- Contention: both requesters valid continuously, 3-byte packets -> grant order 0,1,0,1. Bytes never interleave. Exactly one idle cycle between packets.
- Backpressure: tx_ready toggles 1,0,0,1 during a 4-byte packet -> each byte held until accepted; no data loss or duplication; stall counter stays 0.
- Watchdog: IDLE_TIMEOUT=8; owner 1 sends 1 non-last byte then drops valid -> release after 8 stall cycles, timeout_event high for 1 cycle, requester 0 granted next if pending.
- Reset mid-packet: assert reset for 1 cycle after the 2nd of 4 bytes -> tx_valid=0, grant_valid=0 after that edge. Next grant goes to requester 0 even if 1 requested first in the same cycle.
